npu_wb_initiator: RTL and testbench
===================================

Name: npu_wb_initiator

Overview:
- Wishbone classic initiator that drives the NPU's bus-facing peripheral.
- It turns simple command/data streams into single-outstanding Wishbone cycles: weight loads, input-stream writes and result reads.
- Bursts are issued as back-to-back single cycles with an incrementing address.
- Includes an ack timeout so a missing or unmapped responder cannot hang the sequencer.

Parameters:
AW, 32, address width
DW, 32, data width
LEN_W, 8, width of cmd_len (beats = cmd_len+1)
ADDR_STRIDE, 4, byte increment added to the address per beat
TIMEOUT, 255, cycles of stb without ack before abort; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_we  in  1  1=write burst, 0=read burst
cmd_addr  in  AW  first beat address
cmd_len  in  LEN_W  beats minus one
cmd_sel  in  DW/8  byte select, used for every beat
wr_valid  in  1  write data offered
wr_ready  out  1  write data accepted when both high
wr_data  in  DW  write beat data
rd_valid  out  1  read beat available
rd_ready  in  1  read beat consumed when both high
rd_data  out  DW  read beat data
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at command end (success or abort)
err  out  1  timeout occurred on last command
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_we_o  out  1  write enable
wb_sel_o  out  DW/8  byte select
wb_adr_o  out  AW  address
wb_dat_o  out  DW  write data
wb_dat_i  in  DW  read data
wb_ack_i  in  1  acknowledge

Behaviour:
- Reset: rst is synchronous, active-high, on clk.
  - Forces state IDLE.
  - Clears wb_cyc_o, wb_stb_o, wb_we_o, rd_valid, done and err.
  - Clears the beat counter and the timeout counter.
  - wb_adr_o, wb_dat_o, wb_sel_o and rd_data are cleared to 0.
  - Reset mid-command abandons it with no done pulse. The bus is released at the reset edge.
- Handshakes and outputs:
  - cmd_ready = (state==IDLE). wr_ready = (state==WDATA). busy = (state!=IDLE).
  - All Wishbone outputs, rd_valid and rd_data are registered.
  - wb_cyc_o == wb_stb_o at all times.
- FSM states: IDLE, WDATA, BUS, RESP.
- IDLE:
  - On cmd_valid: latch we, addr, sel and beats_left=cmd_len, then clear err.
  - Go to WDATA if we=1, else go to BUS.
- WDATA:
  - On wr_valid: latch wr_data into wb_dat_o, then go to BUS.
  - Holds indefinitely while wr_valid=0, with stb low.
- BUS:
  - cyc=stb=1 for the whole state.
  - Timeout counter starts at 0 on entry and increments each cycle without ack.
  - wb_ack_i is honoured only while wb_stb_o=1. Ack in any other state is ignored.
  - Ack on a write beat:
    - Drop stb at that edge.
    - If beats_left==0: go to IDLE and pulse done.
    - Otherwise: beats_left-1, addr+ADDR_STRIDE, go to WDATA.
  - Ack on a read beat: drop stb, capture wb_dat_i into rd_data, set rd_valid, go to RESP.
  - Timeout (counter==TIMEOUT-1 with no ack, TIMEOUT>0):
    - Drop stb, set err, pulse done, go to IDLE.
    - The remaining beats are discarded and no further wr_ready or rd_valid is produced.
- RESP:
  - rd_valid and rd_data are held stable until rd_ready.
  - On rd_ready: clear rd_valid.
  - If beats_left==0: go to IDLE and pulse done.
  - Otherwise: decrement beats_left, increment the address, go to BUS.
- Spacing and latency:
  - The FSM guarantees at least one stb-low cycle between beats. This makes it safe with responders whose ack is registered one cycle after stb and may repeat once.
  - Read latency: stb rises in the cycle after command acceptance.
  - Write latency: stb rises in the cycle after wr_data acceptance.
  - Minimum beat period with a 1-cycle-ack responder and ready consumers: 3 cycles.
- Counters and arithmetic:
  - Address wraps modulo 2^AW.
  - cmd_len=0 gives one beat. cmd_len=all-ones gives 2^LEN_W beats.
  - The timeout counter is wide enough for TIMEOUT and saturates when TIMEOUT=0 (disabled).
- err persists until the next command is accepted.
- done and cmd acceptance can occur in adjacent cycles but never in the same cycle.

Test Plan:
1. Single write: cmd_we=1, addr 0x30000000, len 0, sel 0xF, wr_data 0x00AABBCC; responder acks 1 cycle after stb.
   -> One cycle with adr 0x30000000, dat 0x00AABBCC, we=1; stb high exactly 2 cycles; done pulses once; err=0.
2. Weight burst: len 8 at 0x30000000 with data 1..9; wr_valid withheld 3 cycles before beat 4.
   -> 9 cycles at adr 0x30000000..0x30000020 in steps of 4, data in order; stb low throughout the stall.
3. Read burst: len 2 at 0x30000200; responder returns 0x11, 0x22, 0x33; rd_ready low for 5 cycles on beat 1.
   -> rd_data 0x11, 0x22, 0x33 in order; rd_data stable during the stall; no stb until beat 1 is consumed.
4. Timeout: TIMEOUT=16 with no ack.
   -> stb high exactly 16 cycles, then low; err=1; done pulses; no rd_valid. A following good command clears err and completes.
5. Reset mid-burst: assert rst during beat 3 of a len-5 write.
   -> cyc/stb=0 after the edge; busy=0; no done pulse; cmd_ready=1 in the first cycle after rst deasserts.
6. Spurious ack: responder repeats ack one cycle after stb drops.
   -> Ignored; beat count and addresses unchanged; burst completes with the correct number of cycles.

Source files
------------

// File: rtl/npu_wb_initiator.sv
// Wishbone classic initiator for the NPU peripheral port.
// Runs one beat at a time and aborts on a missing ack.
module npu_wb_initiator #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int LEN_W       = 8,
  parameter int ADDR_STRIDE = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DW/8-1:0]   cmd_sel,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DW-1:0]     wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DW-1:0]     rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [AW-1:0]     wb_adr_o,
  output logic [DW-1:0]     wb_dat_o,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic              wb_ack_i
);

  localparam int SW = DW / 8;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    BUS,
    RESP
  } state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] beats, beats_n;
  logic [TW-1:0]    to_cnt, to_n;
  logic [AW-1:0]    adr_n;
  logic [DW-1:0]    dat_n;
  logic [DW-1:0]    rdd_n;
  logic [SW-1:0]    sel_n;
  logic             we_n;
  logic             stb_n;
  logic             rdv_n;
  logic             err_n;
  logic             done_c;
  logic             ack;
  logic             to_hit;
  logic [TW-1:0]    to_inc;

  assign ack       = wb_ack_i & wb_stb_o;
  assign to_hit    = (TIMEOUT > 0) && (to_cnt == TW'(TIMEOUT - 1));
  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WDATA);
  assign busy      = (state != IDLE);
  assign wb_cyc_o  = wb_stb_o;
  // done is the final transition itself, so it precedes the next accept
  assign done      = done_c & ~rst;

  // Disabled timeout: the counter parks at all-ones instead of wrapping
  always_comb begin
    to_inc = to_cnt + 1'b1;
    if (TIMEOUT == 0 && (&to_cnt)) to_inc = to_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beats    <= '0;
      to_cnt   <= '0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      beats    <= beats_n;
      to_cnt   <= to_n;
      wb_stb_o <= stb_n;
      wb_we_o  <= we_n;
      wb_sel_o <= sel_n;
      wb_adr_o <= adr_n;
      wb_dat_o <= dat_n;
      rd_valid <= rdv_n;
      rd_data  <= rdd_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    beats_n = beats;
    to_n    = '0;
    stb_n   = wb_stb_o;
    we_n    = wb_we_o;
    sel_n   = wb_sel_o;
    adr_n   = wb_adr_o;
    dat_n   = wb_dat_o;
    rdv_n   = rd_valid;
    rdd_n   = rd_data;
    err_n   = err;
    done_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          we_n    = cmd_we;
          adr_n   = cmd_addr;
          sel_n   = cmd_sel;
          beats_n = cmd_len;
          err_n   = 1'b0;
          stb_n   = ~cmd_we;
          state_n = cmd_we ? WDATA : BUS;
        end
      end
      WDATA: begin
        if (wr_valid) begin
          dat_n   = wr_data;
          stb_n   = 1'b1;
          state_n = BUS;
        end
      end
      BUS: begin
        to_n = to_inc;
        if (ack) begin
          stb_n = 1'b0;
          if (!wb_we_o) begin
            rdd_n   = wb_dat_i;
            rdv_n   = 1'b1;
            state_n = RESP;
          end else if (beats == '0) begin
            done_c  = 1'b1;
            state_n = IDLE;
          end else begin
            beats_n = beats - 1'b1;
            adr_n   = wb_adr_o + AW'(ADDR_STRIDE);
            state_n = WDATA;
          end
        end else if (to_hit) begin
          stb_n   = 1'b0;
          err_n   = 1'b1;
          done_c  = 1'b1;
          state_n = IDLE;
        end
      end
      RESP: begin
        if (rd_ready) begin
          rdv_n = 1'b0;
          if (beats == '0) begin
            done_c  = 1'b1;
            state_n = IDLE;
          end else begin
            beats_n = beats - 1'b1;
            adr_n   = wb_adr_o + AW'(ADDR_STRIDE);
            stb_n   = 1'b1;
            state_n = BUS;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_npu_wb_initiator.sv
// Directed bench for npu_wb_initiator.
// Bus responder and monitor run alongside a linear step list.
module tb_npu_wb_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_sel;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_ack_i;

  always #5 clk = ~clk;

  npu_wb_initiator #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Responder: ack one cycle after stb; rep repeats it once more
  logic        resp_on = 1'b1;
  logic        rep = 1'b0;
  logic [2:0]  rd_idx = '0;
  logic [31:0] rd_mem [0:7];

  assign wb_dat_i = rd_mem[rd_idx];

  always @(posedge clk) begin
    if (rst) wb_ack_i <= 1'b0;
    else wb_ack_i <= resp_on && wb_stb_o && (!wb_ack_i || rep);
    if (wb_stb_o && wb_ack_i && !wb_we_o) rd_idx <= rd_idx + 1'b1;
  end

  int          stb_cyc = 0, done_cnt = 0, rdv_cnt = 0;
  int          beat_n = 0, cyc_bad = 0;
  logic [31:0] b_adr [0:63];
  logic [31:0] b_dat [0:63];
  logic        b_we  [0:63];
  logic [3:0]  b_sel [0:63];

  always @(negedge clk) begin
    if (!rst) begin
      if (wb_cyc_o !== wb_stb_o) cyc_bad++;
      if (wb_stb_o) stb_cyc++;
      if (done) done_cnt++;
      if (rd_valid) rdv_cnt++;
      if (wb_stb_o && wb_ack_i) begin
        b_adr[beat_n] = wb_adr_o;
        b_dat[beat_n] = wb_we_o ? wb_dat_o : wb_dat_i;
        b_we[beat_n]  = wb_we_o;
        b_sel[beat_n] = wb_sel_o;
        beat_n++;
      end
    end
  end

  task automatic send_cmd(input logic we, input logic [31:0] a,
                          input logic [7:0] len);
    int k = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_sel   = 4'hF;
    while (!cmd_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (k >= 100) chk("cmd_wait", 64'(k), 0);
  endtask

  task automatic send_wr(input logic [31:0] d, input int stall);
    int k = 0;
    wr_valid = 1'b0;
    while (!wr_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 100) chk("wr_wait", 64'(k), 0);
    for (int i = 0; i < stall; i++) begin
      chk("wr_stall_stb", wb_stb_o, 0);
      @(posedge clk); #1;
    end
    wr_valid = 1'b1;
    wr_data  = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    chk("wr_lat_stb", wb_stb_o, 1);
  endtask

  task automatic recv_rd(input int stall, input logic [31:0] exp);
    int k = 0;
    while (!rd_valid && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 100) chk("rd_wait", 64'(k), 0);
    chk("rd_data", rd_data, exp);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("rd_stall_data", rd_data, exp);
      chk("rd_stall_stb", wb_stb_o, 0);
    end
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    chk("rd_valid_clr", rd_valid, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 300) chk("idle_wait", 64'(k), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int s0, d0, b0, r0;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
    cmd_len = '0; cmd_sel = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    rd_mem[0] = 32'h11; rd_mem[1] = 32'h22; rd_mem[2] = 32'h33;
    rd_mem[3] = 32'h44; rd_mem[4] = 32'h55; rd_mem[5] = 32'h0;
    rd_mem[6] = 32'h0;  rd_mem[7] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_adr", wb_adr_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single write
    s0 = stb_cyc; d0 = done_cnt; b0 = beat_n;
    send_cmd(1'b1, 32'h3000_0000, 8'd0);
    chk("t1_busy", busy, 1);
    chk("t1_no_stb", wb_stb_o, 0);
    send_wr(32'h00AA_BBCC, 0);
    wait_idle();
    chk("t1_beats", beat_n - b0, 1);
    chk("t1_adr", b_adr[b0], 32'h3000_0000);
    chk("t1_dat", b_dat[b0], 32'h00AA_BBCC);
    chk("t1_we", b_we[b0], 1);
    chk("t1_sel", b_sel[b0], 4'hF);
    chk("t1_stb_cyc", stb_cyc - s0, 2);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_err", err, 0);

    // 2: weight burst, wr_valid withheld before beat 4
    s0 = stb_cyc; d0 = done_cnt; b0 = beat_n;
    send_cmd(1'b1, 32'h3000_0000, 8'd8);
    for (int i = 0; i < 9; i++)
      send_wr(32'(i + 1), (i == 3) ? 3 : 0);
    wait_idle();
    chk("t2_beats", beat_n - b0, 9);
    for (int i = 0; i < 9; i++) begin
      chk("t2_adr", b_adr[b0 + i], 32'h3000_0000 + 32'(4 * i));
      chk("t2_dat", b_dat[b0 + i], 32'(i + 1));
    end
    chk("t2_stb_cyc", stb_cyc - s0, 18);
    chk("t2_done", done_cnt - d0, 1);

    // 3: read burst with consumer stall on beat 1
    s0 = stb_cyc; d0 = done_cnt; b0 = beat_n;
    send_cmd(1'b0, 32'h3000_0200, 8'd2);
    chk("t3_rd_lat_stb", wb_stb_o, 1);
    recv_rd(5, 32'h11);
    recv_rd(0, 32'h22);
    recv_rd(0, 32'h33);
    wait_idle();
    chk("t3_beats", beat_n - b0, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t3_adr", b_adr[b0 + i], 32'h3000_0200 + 32'(4 * i));
      chk("t3_we", b_we[b0 + i], 0);
    end
    chk("t3_stb_cyc", stb_cyc - s0, 6);
    chk("t3_done", done_cnt - d0, 1);
    chk("t3_err", err, 0);

    // 4: timeout with no responder, then a good command
    resp_on = 1'b0;
    s0 = stb_cyc; d0 = done_cnt; b0 = beat_n; r0 = rdv_cnt;
    send_cmd(1'b0, 32'h4000_0000, 8'd3);
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("t4_stb_cyc", stb_cyc - s0, 16);
    chk("t4_err", err, 1);
    chk("t4_done", done_cnt - d0, 1);
    chk("t4_rdv", rdv_cnt - r0, 0);
    chk("t4_beats", beat_n - b0, 0);
    chk("t4_busy", busy, 0);
    resp_on = 1'b1;
    d0 = done_cnt; b0 = beat_n;
    send_cmd(1'b1, 32'h4000_0100, 8'd0);
    chk("t4_err_clr", err, 0);
    send_wr(32'hCAFE_0001, 0);
    wait_idle();
    chk("t4b_done", done_cnt - d0, 1);
    chk("t4b_beats", beat_n - b0, 1);
    chk("t4b_err", err, 0);

    // 5: reset during beat 3 of a len-5 write
    d0 = done_cnt; b0 = beat_n;
    send_cmd(1'b1, 32'h5000_0000, 8'd5);
    send_wr(32'h5001, 0);
    send_wr(32'h5002, 0);
    send_wr(32'h5003, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_stb", wb_stb_o, 0);
    chk("t5_cyc", wb_cyc_o, 0);
    chk("t5_busy", busy, 0);
    chk("t5_adr", wb_adr_o, 0);
    rst = 1'b0;
    chk("t5_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    chk("t5_done", done_cnt - d0, 0);
    chk("t5_beats", beat_n - b0, 2);
    chk("t5_idle_stb", wb_stb_o, 0);

    // 6: responder repeats each ack once
    rep = 1'b1;
    s0 = stb_cyc; d0 = done_cnt; b0 = beat_n;
    send_cmd(1'b1, 32'h6000_0000, 8'd3);
    for (int i = 0; i < 4; i++)
      send_wr(32'hA0 + 32'(i), 0);
    wait_idle();
    chk("t6_beats", beat_n - b0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t6_adr", b_adr[b0 + i], 32'h6000_0000 + 32'(4 * i));
      chk("t6_dat", b_dat[b0 + i], 32'hA0 + 32'(i));
    end
    chk("t6_stb_cyc", stb_cyc - s0, 8);
    chk("t6_done", done_cnt - d0, 1);
    s0 = stb_cyc; d0 = done_cnt; b0 = beat_n;
    send_cmd(1'b0, 32'h6000_1000, 8'd1);
    recv_rd(0, 32'h44);
    recv_rd(0, 32'h55);
    wait_idle();
    chk("t6r_beats", beat_n - b0, 2);
    chk("t6r_adr0", b_adr[b0], 32'h6000_1000);
    chk("t6r_adr1", b_adr[b0 + 1], 32'h6000_1004);
    chk("t6r_stb_cyc", stb_cyc - s0, 4);
    chk("t6r_done", done_cnt - d0, 1);
    rep = 1'b0;

    chk("cyc_eq_stb", 64'(cyc_bad), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
